// File: rtl/byte_lane_write_sequencer.sv
// byte_lane_write_sequencer: feeds a masked 32-bit word to a one-lane-per-clock byte register,
// driving each selected lane in ascending order for HOLD_CYCLES clocks, then pulsing done.
module byte_lane_write_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_mask,
    output logic [1:0]  reg_byteenable,
    output logic [31:0] reg_d,
    output logic        lane_active,
    output logic        busy,
    output logic        done
);
    if (HOLD_CYCLES < 1) begin : g_hold_check
        $error("HOLD_CYCLES must be at least 1");
    end

    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state;
    logic [3:0]    mask_q;
    logic [CW-1:0] cnt;
    logic [1:0]    first, nxt;
    logic          has_nxt;

    assign in_ready = (state == IDLE) && reset;

    // The current lane lives in reg_byteenable itself; search upward from it.
    always_comb begin
        first = 2'd0;
        nxt = 2'd0;
        has_nxt = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (in_mask[i]) first = 2'(i);
            if (mask_q[i] && 2'(i) > reg_byteenable) begin
                nxt = 2'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mask_q <= 4'd0;
            cnt <= '0;
            reg_byteenable <= 2'd0;
            reg_d <= 32'd0;
            lane_active <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mask_q <= in_mask;
                    cnt <= '0;
                    busy <= 1'b1;
                    if (|in_mask) begin
                        state <= ISSUE;
                        reg_byteenable <= first;
                        reg_d <= in_data;
                        lane_active <= 1'b1;
                    end else begin
                        state <= DONE;
                        done <= 1'b1;
                    end
                end
                ISSUE: if (cnt == LAST) begin
                    cnt <= '0;
                    if (has_nxt) reg_byteenable <= nxt;
                    else begin
                        state <= DONE;
                        lane_active <= 1'b0;
                        done <= 1'b1;
                    end
                end else cnt <= cnt + CW'(1);
                default: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
